// File: rtl/arp_pkg.sv
// Shared definitions for the ARP responder: frame field byte offsets,
// fixed header values, FSM state encodings and the reply buffer payload.
package arp_pkg;

   // Byte offsets of fields within an Ethernet II + ARP frame
   localparam int unsigned DST_OFS   = 0;
   localparam int unsigned SRC_OFS   = 6;
   localparam int unsigned TYPE_OFS  = 12;
   localparam int unsigned OP_OFS    = 20;
   localparam int unsigned SHA_OFS   = 22;
   localparam int unsigned SPA_OFS   = 28;
   localparam int unsigned THA_OFS   = 32;
   localparam int unsigned TPA_OFS   = 38;
   localparam int unsigned ARP_LEN   = 42;
   localparam int unsigned MIN_FRAME = 60;

   // Width of byte counters; must hold MIN_FRAME-1
   localparam int unsigned IDX_W = 6;

   // Fixed header values
   localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
   localparam logic [15:0] HRD_ETH      = 16'h0001;
   localparam logic [15:0] PRO_IPV4     = 16'h0800;
   localparam logic [7:0]  HLN_ETH      = 8'h06;
   localparam logic [7:0]  PLN_IPV4     = 8'h04;
   localparam logic [15:0] OP_REQ       = 16'h0001;
   localparam logic [15:0] OP_REPLY     = 16'h0002;

   typedef enum logic [1:0] {
      RX_IDLE     = 2'd0,
      RX_RECV     = 2'd1,
      RX_WAIT_END = 2'd2
   } rx_state_e;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_e;

   // Everything needed to regenerate one reply frame
   typedef struct packed {
      logic [47:0] sha;
      logic [31:0] spa;
      logic [31:0] ip;
      logic [47:0] mac;
   } reply_buf_t;

endpackage

// File: rtl/arp_responder_multi_if.sv
// Byte-stream bus between the GbE MAC and the ARP responder.
//   DATA_VALID_RX/DATA_RX             : RX frame bytes, MAC -> responder
//   DATA_VALID_TX/DATA_TX/DATA_LAST_TX: reply bytes, responder -> MAC
//   DATA_ACK_TX                       : MAC accepts the current TX byte
// master = MAC side, slave = responder side.
interface arp_responder_multi_if;
   logic       DATA_VALID_RX;
   logic [7:0] DATA_RX;
   logic       DATA_ACK_TX;
   logic       DATA_VALID_TX;
   logic [7:0] DATA_TX;
   logic       DATA_LAST_TX;

   modport master (
      output DATA_VALID_RX, DATA_RX, DATA_ACK_TX,
      input  DATA_VALID_TX, DATA_TX, DATA_LAST_TX
   );

   modport slave (
      input  DATA_VALID_RX, DATA_RX, DATA_ACK_TX,
      output DATA_VALID_TX, DATA_TX, DATA_LAST_TX
   );
endinterface

// File: rtl/arp_rx_parser.sv
// RX side of the ARP responder: walks the incoming frame byte by byte,
// checks the Ethernet/ARP request header, captures SHA/SPA and matches
// TPA against the enabled local IPv4 table.
//   clk, rst_n      : clock, async active-low reset
//   my_mac          : local MAC (unicast destination match)
//   my_ipv4, ip_en  : local IPv4 table and per-entry enables
//   rx_valid/rx_data: RX byte stream
//   commit_c        : one-cycle pulse at frame end for a matching request
//   sha, spa, ip    : requester HA/PA and matched local IP, valid with commit_c
module arp_rx_parser
   import arp_pkg::*;
#(
   parameter int unsigned NUM_IPS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [47:0]            my_mac,
   input  logic [32*NUM_IPS-1:0]  my_ipv4,
   input  logic [NUM_IPS-1:0]     ip_en,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   output logic                   commit_c,
   output logic [47:0]            sha,
   output logic [31:0]            spa,
   output logic [31:0]            ip
);

   localparam logic [79:0] REQ_FIX = {ETH_TYPE_ARP, HRD_ETH, PRO_IPV4,
                                      HLN_ETH, PLN_IPV4, OP_REQ};

   rx_state_e              state_q, state_d;
   logic [IDX_W-1:0]       idx_q;
   logic                   bc_q, uc_q, bc_d, uc_d;
   logic                   hit_q;
   logic [23:0]            tpa_q;
   logic [32*NUM_IPS-1:0]  tbl_q;
   logic [NUM_IPS-1:0]     en_q;
   logic                   active;
   int unsigned            cur;
   logic                   byte_ok;
   logic [31:0]            tpa_full;
   logic                   match_c;
   logic [31:0]            match_ip_c;

   // Byte index of the byte on the bus; the first byte is seen while still in IDLE
   always_comb begin
      active = rx_valid && (state_q != RX_WAIT_END);
      cur    = (state_q == RX_IDLE) ? 0 : 32'(idx_q);
   end

   // Header checks; destination is judged once all six bytes are in
   always_comb begin
      byte_ok = 1'b1;
      bc_d    = (state_q == RX_IDLE) | bc_q;
      uc_d    = (state_q == RX_IDLE) | uc_q;
      if (cur < SRC_OFS) begin
         bc_d = bc_d & (rx_data == 8'hFF);
         uc_d = uc_d & (rx_data == 8'(my_mac >> (8 * (SRC_OFS - 1 - cur + DST_OFS))));
         if (cur == SRC_OFS - 1) byte_ok = bc_d | uc_d;
      end else if (cur >= TYPE_OFS && cur < OP_OFS + 2) begin
         byte_ok = (rx_data == 8'(REQ_FIX >> (8 * (OP_OFS + 1 - cur))));
      end
   end

   // TPA against the snapshot table, lowest enabled index wins
   always_comb begin
      tpa_full   = {tpa_q, rx_data};
      match_c    = 1'b0;
      match_ip_c = '0;
      for (int unsigned k = 0; k < NUM_IPS; k++) begin
         if (!match_c && en_q[k] && (tbl_q[32*k +: 32] == tpa_full)) begin
            match_c    = 1'b1;
            match_ip_c = tbl_q[32*k +: 32];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RX_IDLE;
      else        state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE:
            if (rx_valid) state_d = byte_ok ? RX_RECV : RX_WAIT_END;
         RX_RECV:
            if (!rx_valid)                             state_d = RX_IDLE;
            else if (!byte_ok || cur == ARP_LEN - 1)   state_d = RX_WAIT_END;
         RX_WAIT_END:
            if (!rx_valid) state_d = RX_IDLE;
         default: state_d = RX_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      commit_c = 1'b0;
      if (state_q == RX_WAIT_END && !rx_valid && hit_q) commit_c = 1'b1;
   end

   // Field capture; the table snapshot freezes for the duration of a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         bc_q  <= 1'b0;
         uc_q  <= 1'b0;
         hit_q <= 1'b0;
         tpa_q <= '0;
         tbl_q <= '0;
         en_q  <= '0;
         sha   <= '0;
         spa   <= '0;
         ip    <= '0;
      end else begin
         if (state_q == RX_IDLE) begin
            tbl_q <= my_ipv4;
            en_q  <= ip_en;
            hit_q <= 1'b0;
         end
         if (active) begin
            idx_q <= IDX_W'(cur + 1);
            bc_q  <= bc_d;
            uc_q  <= uc_d;
            if (cur >= SHA_OFS && cur < SPA_OFS) sha   <= {sha[39:0], rx_data};
            if (cur >= SPA_OFS && cur < THA_OFS) spa   <= {spa[23:0], rx_data};
            if (cur >= TPA_OFS && cur < ARP_LEN - 1) tpa_q <= {tpa_q[15:0], rx_data};
            if (cur == ARP_LEN - 1) begin
               hit_q <= match_c;
               ip    <= match_ip_c;
            end
         end
      end
   end

endmodule

// File: rtl/arp_responder_multi.sv
// ARP responder answering requests for up to NUM_IPS local IPv4 addresses.
// RX parsing lives in arp_rx_parser; this level holds the one-deep reply
// buffer, the TX FSM and the saturating statistics counters.
//   CLK, ARESETN          : clock, async active-low reset
//   MY_MAC, MY_IPV4, IP_EN: quasi-static identity configuration
//   bus                   : RX/TX byte streams (slave side)
//   REQ_CNT, REPLY_CNT, DROP_CNT: statistics
module arp_responder_multi
   import arp_pkg::*;
#(
   parameter int unsigned NUM_IPS    = 4,
   parameter int unsigned PAD_TO_MIN = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                   CLK,
   input  logic                   ARESETN,
   input  logic [47:0]            MY_MAC,
   input  logic [32*NUM_IPS-1:0]  MY_IPV4,
   input  logic [NUM_IPS-1:0]     IP_EN,
   arp_responder_multi_if.slave   bus,
   output logic [CNT_W-1:0]       REQ_CNT,
   output logic [CNT_W-1:0]       REPLY_CNT,
   output logic [CNT_W-1:0]       DROP_CNT
);

   localparam int unsigned LAST_IDX = (PAD_TO_MIN != 0) ? MIN_FRAME - 1 : ARP_LEN - 1;
   localparam logic [79:0] REPLY_FIX = {ETH_TYPE_ARP, HRD_ETH, PRO_IPV4,
                                        HLN_ETH, PLN_IPV4, OP_REPLY};

   logic             commit_c;
   logic [47:0]      rx_sha;
   logic [31:0]      rx_spa;
   logic [31:0]      rx_ip;
   tx_state_e        state_q, state_d;
   logic [IDX_W-1:0] tx_idx_q;
   reply_buf_t       buf_q;
   logic             last_c;
   logic             beat_c;
   logic             done_c;
   logic [7:0]       byte_c;
   int unsigned      ti;

   arp_rx_parser #(.NUM_IPS(NUM_IPS)) u_rx (
      .clk      (CLK),
      .rst_n    (ARESETN),
      .my_mac   (MY_MAC),
      .my_ipv4  (MY_IPV4),
      .ip_en    (IP_EN),
      .rx_valid (bus.DATA_VALID_RX),
      .rx_data  (bus.DATA_RX),
      .commit_c (commit_c),
      .sha      (rx_sha),
      .spa      (rx_spa),
      .ip       (rx_ip)
   );

   always_comb begin
      last_c = (32'(tx_idx_q) == LAST_IDX);
      beat_c = (state_q == TX_SEND) && bus.DATA_ACK_TX;
      done_c = beat_c && last_c;
   end

   // Reply byte at the current TX index; past ARP_LEN it is padding
   always_comb begin
      ti     = 32'(tx_idx_q);
      byte_c = 8'h00;
      if (ti < SRC_OFS)       byte_c = 8'(buf_q.sha >> (8 * (SRC_OFS - 1 - ti + DST_OFS)));
      else if (ti < TYPE_OFS) byte_c = 8'(buf_q.mac >> (8 * (TYPE_OFS - 1 - ti)));
      else if (ti < SHA_OFS)  byte_c = 8'(REPLY_FIX >> (8 * (SHA_OFS - 1 - ti)));
      else if (ti < SPA_OFS)  byte_c = 8'(buf_q.mac >> (8 * (SPA_OFS - 1 - ti)));
      else if (ti < THA_OFS)  byte_c = 8'(buf_q.ip  >> (8 * (THA_OFS - 1 - ti)));
      else if (ti < TPA_OFS)  byte_c = 8'(buf_q.sha >> (8 * (TPA_OFS - 1 - ti)));
      else if (ti < ARP_LEN)  byte_c = 8'(buf_q.spa >> (8 * (ARP_LEN - 1 - ti)));
   end

   // TX state register
   always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) state_q <= TX_IDLE;
      else          state_q <= state_d;
   end

   // TX next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         TX_IDLE: if (commit_c) state_d = TX_SEND;
         TX_SEND: if (done_c)   state_d = TX_IDLE;
         default: state_d = TX_IDLE;
      endcase
   end

   // TX outputs, decoded from registered state, index and buffer only
   always_comb begin
      bus.DATA_VALID_TX = 1'b0;
      bus.DATA_TX       = 8'h00;
      bus.DATA_LAST_TX  = 1'b0;
      if (state_q == TX_SEND) begin
         bus.DATA_VALID_TX = 1'b1;
         bus.DATA_TX       = byte_c;
         bus.DATA_LAST_TX  = last_c;
      end
   end

   // Reply buffer loads only when TX is idle; index advances per accepted byte
   always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) begin
         buf_q    <= '0;
         tx_idx_q <= '0;
      end else if (state_q == TX_IDLE && commit_c) begin
         buf_q    <= '{sha: rx_sha, spa: rx_spa, ip: rx_ip, mac: MY_MAC};
         tx_idx_q <= '0;
      end else if (beat_c) begin
         tx_idx_q <= IDX_W'(tx_idx_q + 1'b1);
      end
   end

   // Saturating statistics; a commit while TX is not idle is a drop
   always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) begin
         REQ_CNT   <= '0;
         REPLY_CNT <= '0;
         DROP_CNT  <= '0;
      end else begin
         if (commit_c && REQ_CNT != '1)
            REQ_CNT <= CNT_W'(REQ_CNT + 1'b1);
         if (commit_c && state_q != TX_IDLE && DROP_CNT != '1)
            DROP_CNT <= CNT_W'(DROP_CNT + 1'b1);
         if (done_c && REPLY_CNT != '1)
            REPLY_CNT <= CNT_W'(REPLY_CNT + 1'b1);
      end
   end

endmodule

// File: tb/tb_arp_responder_multi.sv
// Self-checking bench for arp_responder_multi: expected reply bytes are
// queued when a request is driven and compared as the DUT emits them.
module tb_arp_responder_multi;

   localparam logic [47:0] MAC   = 48'h0002_2301_0203;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] MCAST = 48'h0100_5E00_0001;
   localparam logic [47:0] SHA_A = 48'h0001_4200_5F68;
   localparam logic [47:0] SHA_B = 48'h0A0B_0C0D_0E0F;
   localparam logic [31:0] SPA_A = 32'hC0A8_0101;
   localparam logic [31:0] SPA_B = 32'hC0A8_0164;
   localparam logic [31:0] IP0   = 32'hC0A8_0102;
   localparam logic [31:0] IP1   = 32'hC0A8_0103;
   localparam logic [31:0] IP2   = 32'hC0A8_0105;
   localparam logic [31:0] IP3   = 32'hC0A8_0107;

   logic         CLK = 1'b0;
   logic         ARESETN = 1'b0;
   logic [47:0]  MY_MAC;
   logic [127:0] MY_IPV4;
   logic [3:0]   IP_EN;
   logic [15:0]  REQ_CNT, REPLY_CNT, DROP_CNT;

   arp_responder_multi_if bus();

   arp_responder_multi #(.NUM_IPS(4), .PAD_TO_MIN(1), .CNT_W(16)) dut (
      .CLK       (CLK),
      .ARESETN   (ARESETN),
      .MY_MAC    (MY_MAC),
      .MY_IPV4   (MY_IPV4),
      .IP_EN     (IP_EN),
      .bus       (bus),
      .REQ_CNT   (REQ_CNT),
      .REPLY_CNT (REPLY_CNT),
      .DROP_CNT  (DROP_CNT)
   );

   always #4 CLK = ~CLK;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];
   logic [8:0] exp_e;
   int         pops = 0;
   int         tx_cycles = 0;
   int         ack_mode = 1;
   int         ack_ph = 0;
   logic       held = 1'b0;
   logic [8:0] held_v;

   // Reply byte i, from the literal reply layout
   function automatic logic [7:0] exp_byte(int i, logic [47:0] sha, logic [31:0] spa,
                                           logic [31:0] ip);
      logic [335:0] r;
      r = {sha, MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
           MAC, ip, sha, spa};
      if (i < 42) return r[8*(41-i) +: 8];
      return 8'h00;
   endfunction

   task automatic push_reply(input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] ip);
      for (int i = 0; i < 60; i++)
         exp_q.push_back({(i == 59), exp_byte(i, sha, spa, ip)});
   endtask

   // Drives one frame; returns just after DATA_VALID_RX drops
   task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype,
                             input logic [15:0] op, input logic [47:0] sha,
                             input logic [31:0] spa, input logic [31:0] tpa, input int len);
      logic [335:0] h;
      logic [7:0]   fr[60];
      h = {dst, sha, etype, 16'h0001, 16'h0800, 8'h06, 8'h04, op, sha, spa, 48'h0, tpa};
      for (int i = 0; i < 60; i++) fr[i] = (i < 42) ? h[8*(41-i) +: 8] : 8'h00;
      for (int i = 0; i < len; i++) begin
         @(posedge CLK); #1;
         bus.DATA_VALID_RX = 1'b1;
         bus.DATA_RX       = fr[i];
      end
      @(posedge CLK); #1;
      bus.DATA_VALID_RX = 1'b0;
      bus.DATA_RX       = 8'h00;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || bus.DATA_VALID_TX) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout: %0d bytes still pending after %0d cycles", name,
                  exp_q.size(), budget);
      end
      repeat (4) @(negedge CLK);
   endtask

   // Ack pattern generator: 0 = low, 1 = high, 2 = high one cycle in three
   initial begin
      bus.DATA_ACK_TX = 1'b0;
      forever begin
         @(posedge CLK); #1;
         case (ack_mode)
            0: bus.DATA_ACK_TX = 1'b0;
            1: bus.DATA_ACK_TX = 1'b1;
            default: begin
               bus.DATA_ACK_TX = (ack_ph == 2);
               ack_ph = (ack_ph + 1) % 3;
            end
         endcase
      end
   end

   // TX monitor: scoreboard pop on accepted bytes, stability while stalled
   always @(negedge CLK) begin
      if (!ARESETN) begin
         held = 1'b0;
      end else begin
         if (bus.DATA_VALID_TX) tx_cycles++;
         if (held && bus.DATA_VALID_TX) begin
            checks++;
            if ({bus.DATA_LAST_TX, bus.DATA_TX} !== held_v) begin
               errors++;
               $display("FAIL tx_stable: got %h required %h", {bus.DATA_LAST_TX, bus.DATA_TX},
                        held_v);
            end
         end
         held   = bus.DATA_VALID_TX && !bus.DATA_ACK_TX;
         held_v = {bus.DATA_LAST_TX, bus.DATA_TX};
         if (bus.DATA_VALID_TX && bus.DATA_ACK_TX) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL tx_unexpected: got byte %h last %b, none expected",
                        bus.DATA_TX, bus.DATA_LAST_TX);
            end else begin
               exp_e = exp_q.pop_front();
               if ({bus.DATA_LAST_TX, bus.DATA_TX} !== exp_e) begin
                  errors++;
                  $display("FAIL tx_byte[%0d]: got last/byte %h required %h", pops,
                           {bus.DATA_LAST_TX, bus.DATA_TX}, exp_e);
               end
               pops++;
            end
         end
      end
   end

   task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      bus.DATA_VALID_RX = 1'b0;
      bus.DATA_RX       = 8'h00;
      MY_MAC  = MAC;
      MY_IPV4 = {IP3, IP2, IP1, IP0};
      IP_EN   = 4'hF;
      ARESETN = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (bus.DATA_VALID_TX !== 1'b0 || bus.DATA_LAST_TX !== 1'b0) begin
         errors++;
         $display("FAIL reset_tx: got valid %b last %b required 0 0", bus.DATA_VALID_TX,
                  bus.DATA_LAST_TX);
      end
      check_cnt("reset_req", REQ_CNT, 16'd0);
      check_cnt("reset_reply", REPLY_CNT, 16'd0);
      check_cnt("reset_drop", DROP_CNT, 16'd0);
      @(posedge CLK); #1;
      ARESETN = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_malformed();
      ack_mode  = 1;
      tx_cycles = 0;
      send_frame(BCAST, 16'h0806, 16'h0002, SHA_A, SPA_A, IP0, 60);
      repeat (8) @(negedge CLK);
      send_frame(BCAST, 16'h0800, 16'h0001, SHA_A, SPA_A, IP0, 60);
      repeat (8) @(negedge CLK);
      send_frame(MCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, IP0, 60);
      repeat (8) @(negedge CLK);
      send_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, IP0, 30);
      repeat (8) @(negedge CLK);
      check_cnt("malformed_tx_cycles", 16'(tx_cycles), 16'd0);
      check_cnt("malformed_req", REQ_CNT, 16'd0);
      check_cnt("malformed_reply", REPLY_CNT, 16'd0);
      check_cnt("malformed_drop", DROP_CNT, 16'd0);
   endtask

   task automatic test_broadcast();
      ack_mode = 1;
      pops     = 0;
      push_reply(SHA_A, SPA_A, IP0);
      send_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, IP0, 60);
      @(negedge CLK);
      checks++;
      if (bus.DATA_VALID_TX !== 1'b0) begin
         errors++;
         $display("FAIL commit_cycle_valid: got %b required 0", bus.DATA_VALID_TX);
      end
      @(negedge CLK);
      checks++;
      if (bus.DATA_VALID_TX !== 1'b1) begin
         errors++;
         $display("FAIL commit_next_valid: got %b required 1", bus.DATA_VALID_TX);
      end
      wait_idle("broadcast", 300);
      check_cnt("broadcast_bytes", 16'(pops), 16'd60);
      check_cnt("broadcast_req", REQ_CNT, 16'd1);
      check_cnt("broadcast_reply", REPLY_CNT, 16'd1);
      check_cnt("broadcast_drop", DROP_CNT, 16'd0);
   endtask

   task automatic test_entry2();
      ack_mode = 1;
      pops     = 0;
      IP_EN    = 4'b0101;
      push_reply(SHA_B, SPA_B, IP2);
      send_frame(MAC, 16'h0806, 16'h0001, SHA_B, SPA_B, IP2, 60);
      wait_idle("entry2", 300);
      check_cnt("entry2_bytes", 16'(pops), 16'd60);
      check_cnt("entry2_req", REQ_CNT, 16'd2);
      check_cnt("entry2_reply", REPLY_CNT, 16'd2);
      IP_EN     = 4'b0001;
      tx_cycles = 0;
      send_frame(MAC, 16'h0806, 16'h0001, SHA_B, SPA_B, IP2, 60);
      repeat (10) @(negedge CLK);
      check_cnt("disabled_tx_cycles", 16'(tx_cycles), 16'd0);
      check_cnt("disabled_req", REQ_CNT, 16'd2);
      IP_EN = 4'hF;
   endtask

   task automatic test_ack_toggle();
      ack_mode = 2;
      pops     = 0;
      push_reply(SHA_A, SPA_A, IP0);
      send_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, IP0, 60);
      wait_idle("ack_toggle", 400);
      check_cnt("ack_toggle_bytes", 16'(pops), 16'd60);
      check_cnt("ack_toggle_reply", REPLY_CNT, 16'd3);
      ack_mode = 1;
   endtask

   task automatic test_back_to_back();
      ack_mode = 0;
      pops     = 0;
      push_reply(SHA_A, SPA_A, IP1);
      send_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, IP1, 60);
      send_frame(BCAST, 16'h0806, 16'h0001, SHA_B, SPA_B, IP3, 60);
      repeat (5) @(negedge CLK);
      checks++;
      if (bus.DATA_VALID_TX !== 1'b1) begin
         errors++;
         $display("FAIL stalled_valid: got %b required 1", bus.DATA_VALID_TX);
      end
      ack_mode = 1;
      wait_idle("back_to_back", 300);
      repeat (10) @(negedge CLK);
      check_cnt("b2b_bytes", 16'(pops), 16'd60);
      check_cnt("b2b_req", REQ_CNT, 16'd5);
      check_cnt("b2b_drop", DROP_CNT, 16'd1);
      check_cnt("b2b_reply", REPLY_CNT, 16'd4);
   endtask

   task automatic test_reset_mid_tx();
      int n = 0;
      ack_mode = 1;
      pops     = 0;
      push_reply(SHA_A, SPA_A, IP0);
      send_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, IP0, 60);
      while (pops < 20 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (pops < 20) begin
         errors++;
         $display("FAIL midtx_reach: got %0d bytes required 20", pops);
      end
      @(posedge CLK); #2;
      ARESETN = 1'b0;
      #1;
      checks++;
      if (bus.DATA_VALID_TX !== 1'b0 || bus.DATA_LAST_TX !== 1'b0) begin
         errors++;
         $display("FAIL midtx_reset_tx: got valid %b last %b required 0 0",
                  bus.DATA_VALID_TX, bus.DATA_LAST_TX);
      end
      exp_q.delete();
      check_cnt("midtx_reset_req", REQ_CNT, 16'd0);
      check_cnt("midtx_reset_reply", REPLY_CNT, 16'd0);
      repeat (2) @(posedge CLK);
      #1;
      ARESETN = 1'b1;
      repeat (2) @(negedge CLK);
      pops = 0;
      push_reply(SHA_B, SPA_B, IP2);
      send_frame(BCAST, 16'h0806, 16'h0001, SHA_B, SPA_B, IP2, 60);
      wait_idle("after_reset", 300);
      check_cnt("after_reset_bytes", 16'(pops), 16'd60);
      check_cnt("after_reset_req", REQ_CNT, 16'd1);
      check_cnt("after_reset_reply", REPLY_CNT, 16'd1);
   endtask

   initial begin
      test_reset();
      test_malformed();
      test_broadcast();
      test_entry2();
      test_ack_toggle();
      test_back_to_back();
      test_reset_mid_tx();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
